// File: rtl/cache_line_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped line controller.
//   S_OFFSET : byte-offset bits (32-byte lines)
//   S_INDEX  : set-index bits (8 sets)
//   S_TAG    : remaining address bits kept as the tag
//   state_e  : controller states, also exported for debug
//   da_sel_e : data-array write-data source
// Optional perf counters are enabled with the CACHE_PERF_CNT_EN macro (see top).
package cache_line_ctrl_pkg;
  localparam int S_OFFSET  = 5;
  localparam int S_INDEX   = 3;
  localparam int S_TAG     = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS  = 1 << S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  typedef enum logic {
    DA_SEL_CPU  = 1'b0,
    DA_SEL_PMEM = 1'b1
  } da_sel_e;

  // Line-aligned byte address from tag and set index.
  function automatic logic [31:0] line_addr(input logic [S_TAG-1:0] tag,
                                            input logic [S_INDEX-1:0] idx);
    return {tag, idx, {S_OFFSET{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_line_ctrl_if.sv
// Bus bundle between the CPU line adapter, the line data array and pmem.
//   CPU side   : mem_address, mem_read, mem_write, mem_byte_enable256 -> ctrl; mem_resp <- ctrl
//   Data array : da_index, da_write_en, da_sel_pmem <- ctrl
//   Memory     : pmem_address, pmem_read, pmem_write <- ctrl; pmem_resp -> ctrl
// Handshake: a requester raises its strobe (mem_read/mem_write, or pmem_read/pmem_write)
// and holds it together with its address until the responder pulses the matching resp
// for exactly one cycle; the strobe may drop on the cycle after resp.
// modport slave is the controller, modport master is the environment driving it.
interface cache_line_ctrl_if;
  import cache_line_ctrl_pkg::*;

  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_byte_enable256;
  logic               mem_resp;
  logic [S_INDEX-1:0] da_index;
  logic [31:0]        da_write_en;
  da_sel_e            da_sel_pmem;
  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic               pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable256, pmem_resp,
    output mem_resp, da_index, da_write_en, da_sel_pmem, pmem_address, pmem_read, pmem_write
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable256, pmem_resp,
    input  mem_resp, da_index, da_write_en, da_sel_pmem, pmem_address, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_meta_array.sv
// Tag/valid/dirty metadata for every set.
//   clk, rst      : clock, asynchronous active-high reset (clears valid/dirty only)
//   i_index       : set for both the combinational read and the write
//   i_tag         : tag written when i_load_tag
//   i_load_valid  : mark the set valid
//   i_load_dirty  : write i_dirty_val into the dirty bit
//   i_load_tag    : write i_tag into the tag array
//   o_valid/o_dirty/o_tag : current metadata of set i_index
module cache_meta_array
  import cache_line_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] i_index,
  input  logic [S_TAG-1:0]   i_tag,
  input  logic               i_load_valid,
  input  logic               i_load_dirty,
  input  logic               i_dirty_val,
  input  logic               i_load_tag,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [S_TAG-1:0]   o_tag
);
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [S_TAG-1:0]    r_tag [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_load_valid) r_valid[i_index] <= 1'b1;
      if (i_load_dirty) r_dirty[i_index] <= i_dirty_val;
    end
  end

  // Tags are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_load_tag) r_tag[i_index] <= i_tag;
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
endmodule

// File: rtl/cache_line_ctrl.sv
// Direct-mapped, write-back, write-allocate line controller.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : cache_line_ctrl_if.slave (CPU request/resp, data-array control, pmem handshake)
//   o_dbg_state : current FSM state
//   hit_count, miss_count : saturating event counters, present only when
//                           CACHE_PERF_CNT_EN is defined
// Hits respond in the request cycle. A miss writes back a dirty victim (WRITEBACK),
// fetches the line (FILL), returns to IDLE, and the still-held request then hits.
module cache_line_ctrl
  import cache_line_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cache_line_ctrl_if.slave     bus,
  output state_e               o_dbg_state
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);
  state_e             r_state;
  state_e             w_state_next;
  logic [S_INDEX-1:0] w_idx;
  logic [S_TAG-1:0]   w_tag;
  logic               w_req;
  logic               w_hit;
  logic               w_valid;
  logic               w_dirty;
  logic [S_TAG-1:0]   w_tag_stored;
  logic               w_load_valid;
  logic               w_load_dirty;
  logic               w_dirty_val;
  logic               w_load_tag;
  logic               w_offset_unused;

  assign w_idx           = bus.mem_address[S_OFFSET +: S_INDEX];
  assign w_tag           = bus.mem_address[31 -: S_TAG];
  assign w_req           = bus.mem_read | bus.mem_write;
  assign w_hit           = w_valid & (w_tag_stored == w_tag);
  assign w_offset_unused = ^bus.mem_address[S_OFFSET-1:0];
  assign bus.da_index    = w_idx;
  assign o_dbg_state     = r_state;

  cache_meta_array u_meta (
    .clk          (clk),
    .rst          (rst),
    .i_index      (w_idx),
    .i_tag        (w_tag),
    .i_load_valid (w_load_valid),
    .i_load_dirty (w_load_dirty),
    .i_dirty_val  (w_dirty_val),
    .i_load_tag   (w_load_tag),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_tag_stored)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    bus.mem_resp       = 1'b0;
    bus.da_write_en    = '0;
    bus.da_sel_pmem    = DA_SEL_CPU;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    bus.pmem_address   = '0;
    w_load_valid       = 1'b0;
    w_load_dirty       = 1'b0;
    w_dirty_val        = 1'b0;
    w_load_tag         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            bus.mem_resp = 1'b1;
            // A combined read+write is a write.
            if (bus.mem_write) begin
              bus.da_write_en = bus.mem_byte_enable256;
              w_load_dirty    = 1'b1;
              w_dirty_val     = 1'b1;
            end
          end else if (w_valid && w_dirty) begin
            w_state_next = WRITEBACK;
          end else begin
            w_state_next = FILL;
          end
        end
      end
      WRITEBACK: begin
        // Victim address comes from the stored tag, not the request.
        bus.pmem_write   = 1'b1;
        bus.pmem_address = line_addr(w_tag_stored, w_idx);
        if (bus.pmem_resp) begin
          w_load_dirty = 1'b1;
          w_dirty_val  = 1'b0;
          w_state_next = FILL;
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = line_addr(w_tag, w_idx);
        if (bus.pmem_resp) begin
          bus.da_write_en = '1;
          bus.da_sel_pmem = DA_SEL_PMEM;
          w_load_tag      = 1'b1;
          w_load_valid    = 1'b1;
          w_load_dirty    = 1'b1;
          w_dirty_val     = 1'b0;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic w_hit_evt;
  logic w_miss_evt;
  assign w_hit_evt  = (r_state == IDLE) & w_req & w_hit;
  assign w_miss_evt = (r_state == IDLE) & w_req & ~w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_evt && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (w_miss_evt && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
- Direct-mapped, write-back, write-allocate controller that sequences the 256-bit line data array.
- Holds tag/valid/dirty metadata and arbitrates array writes between CPU stores and memory line fills.
- Runs writeback/fill handshakes with physical memory.
- Sits between the pipeline's line adapter (CPU side) and the arbiter/pmem (memory side).

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes (32)
s_index, 3, set-index bits; num_sets = 2**s_index (8)
s_tag, 32-s_offset-s_index, tag bits (24)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mem_address  in  32  CPU byte address; stable until mem_resp
mem_read  in  1  CPU line read request
mem_write  in  1  CPU write request
mem_byte_enable256  in  32  byte mask for CPU write
mem_resp  out  1  CPU request complete (1-cycle pulse)
da_index  out  s_index  read/write set index to data array
da_write_en  out  32  byte write mask to data array
da_sel_pmem  out  1  data-array datain mux select: 0 = CPU wdata, 1 = pmem rdata
pmem_address  out  32  line-aligned memory address
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request (data = data-array dataout)
pmem_resp  in  1  memory transfer complete

Behaviour:
- Reset (async, immediate): state IDLE; all valid/dirty = 0; mem_resp, pmem_read, pmem_write, da_write_en = 0; da_sel_pmem = 0. Data-array contents are not reset; validity comes from valid bits only.
- idx = mem_address[s_offset +: s_index]; tag = mem_address[31 -: s_tag]. da_index = idx in every state.
- hit = valid[idx] & (tag_arr[idx] == tag).
- IDLE:
  - No request: all outputs 0.
  - Read hit: mem_resp=1 combinationally, same cycle.
  - Write hit: mem_resp=1; da_write_en = mem_byte_enable256; da_sel_pmem=0; dirty[idx]<=1 at clock edge.
  - Miss: go to WRITEBACK if valid[idx] & dirty[idx], else FILL.
  - mem_read & mem_write together: treated as write.
- WRITEBACK:
  - pmem_write=1; pmem_address = {tag_arr[idx], idx, s_offset'0}.
  - Hold until pmem_resp, then dirty[idx]<=0 and go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {tag, idx, s_offset'0}.
  - On pmem_resp: da_write_en = all ones; da_sel_pmem=1; tag_arr[idx]<=tag; valid[idx]<=1; dirty[idx]<=0; go to IDLE.
  - The retried request then hits on the next cycle.
- Latency:
  - Hit: 0 cycles (resp in request cycle).
  - Clean miss: fill-resp cycle + 1.
  - Dirty miss: adds the writeback handshake.
- pmem_resp in IDLE is ignored.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never asserted together.
- Reset mid-WRITEBACK/FILL: pmem strobes drop immediately, metadata cleared, no partial array write.
- Request withdrawn in IDLE: no state change.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments once per hit response.
  - miss_count increments once per IDLE->WRITEBACK/FILL transition.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cache_line_ctrl_pkg:
  - state enum (IDLE, WRITEBACK, FILL)
  - da_sel enum (DA_SEL_CPU, DA_SEL_PMEM)
  - default s_offset/s_index localparams
- Sub-module cache_meta_array: tag/valid/dirty arrays.
  - Async reset of valid/dirty.
  - Combinational read, synchronous write; separate load_valid/load_dirty/load_tag enables.

Test Plan:
- Reset, then read 0x0000_0040 -> pmem_read=1, pmem_address=0x0000_0040; pmem_resp -> da_write_en=32'hFFFF_FFFF, da_sel_pmem=1; next cycle mem_resp=1.
- Write 0x0000_0044, byte_enable=32'h0000_00F0 after that fill -> same-cycle mem_resp=1, da_write_en=32'h0000_00F0, da_sel_pmem=0; dirty[2]=1.
- Read 0x0000_1040 (same idx 2, new tag) -> pmem_write=1 at 0x0000_0040 until pmem_resp; then pmem_read at 0x0000_1040; mem_resp one cycle after fill.
- Read conflict on clean set -> no pmem_write; straight to FILL.
- Assert rst mid-FILL -> pmem_read=0 same cycle; re-read of the prior hit line misses.
- With CACHE_PERF_CNT_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2.
